// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_pkg
// Description : Shared constants and types for the sliced wide adder.
//               SLICE_W    - width of the shared ripple adder
//               wa_state_t - controller states (IDLE, RUN, DONE)
// Revision    : 1.0 - initial release
// ============================================================================
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wa_state_t;

    // The slice index is one bit wider than strictly needed so that a
    // single-slice configuration still has a non-zero-width counter.
    function automatic int idx_width(input int num_slices);
        return $clog2(num_slices) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_adder16.sv
`default_nettype none
// ============================================================================
// Module      : carry_adder16
// Description : Purely combinational SLICE_W-bit ripple-carry adder.
//               Ports:
//                 x    in  [15:0] operand slice
//                 y    in  [15:0] operand slice (already inverted for sub)
//                 cin  in  1      carry in
//                 s    out [15:0] sum slice
//                 cout out 1      carry out of bit 15
// Revision    : 1.0 - initial release
// ============================================================================
module carry_adder16
    import wide_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        logic w_p;
        assign w_p        = x[i] ^ y[i];
        assign s[i]       = w_p ^ w_c[i];
        assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & w_p);
    end

    assign cout = w_c[SLICE_W];

endmodule
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_seq
// Description : Multi-cycle wide adder/subtractor. One operation of
//               NUM_SLICES*16 bits is accepted per handshake and processed
//               one 16-bit slice per cycle, LSB slice first, through a single
//               shared ripple adder chained by a carry register.
//               Ports:
//                 Clk        in  1  clock, rising edge
//                 Reset_n    in  1  asynchronous active-low reset
//                 in_valid   in  1  operation offered
//                 in_ready   out 1  block is IDLE and can accept
//                 op         in  1  0 = A+B, 1 = A-B
//                 A, B       in  W  operands
//                 out_valid  out 1  result available (DONE)
//                 out_ready  in  1  consumer takes the result
//                 Sum        out W  result
//                 CO         out 1  carry out (sub: 1 = no borrow)
//                 V          out 1  signed overflow
//                 busy       out 1  state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          op,
    input  logic [SLICE_W*NUM_SLICES-1:0] A,
    input  logic [SLICE_W*NUM_SLICES-1:0] B,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] Sum,
    output logic                          CO,
    output logic                          V,
    output logic                          busy
);

    localparam int c_width = SLICE_W * NUM_SLICES;
    localparam int c_idx_w = idx_width(NUM_SLICES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_SLICES - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    wa_state_t            r_state;
    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;      // B, pre-inverted for subtraction
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic [c_width-1:0]   r_sum;
    logic                 r_v;

    // ------------------------------------------------------------------
    // Slice mux feeding the shared adder
    // ------------------------------------------------------------------
    logic [SLICE_W-1:0]   w_x;
    logic [SLICE_W-1:0]   w_y;
    logic [SLICE_W-1:0]   w_s;
    logic                 w_cout;
    logic                 w_last;
    logic                 w_v_next;

    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_x = r_a[i*SLICE_W +: SLICE_W];
                w_y = r_b[i*SLICE_W +: SLICE_W];
            end
        end
    end

    carry_adder16 u_adder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // The last slice is detected explicitly; the counter never wraps.
    assign w_last = (r_idx == c_last_idx);

    // Overflow: operands (after inversion for subtract) share a sign and the
    // result sign differs. Only evaluated on the top slice, where w_s carries
    // the final result MSB.
    assign w_v_next = (r_a[c_width-1] == r_b[c_width-1]) &&
                      (w_s[SLICE_W-1] != r_a[c_width-1]);

    // ------------------------------------------------------------------
    // Controller, operand, carry and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= op ? ~B : B;
                        r_idx   <= '0;
                        // A - B = A + ~B + 1: the +1 enters as carry-in.
                        r_carry <= op;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (r_idx == c_idx_w'(i)) begin
                            r_sum[i*SLICE_W +: SLICE_W] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_v     <= w_v_next;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers are untouched here so the output
                    // holds steady under backpressure.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, no input-to-output path
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign Sum       = r_sum;
    assign CO        = r_carry;
    assign V         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_seq
// Description : Self-checking bench for wide_add_seq (NUM_SLICES = 4).
//               Directed corner cases, backpressure, mid-operation reset and
//               randomized operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int NS = 4;
    localparam int W  = 16 * NS;

    logic         Clk       = 1'b0;
    logic         Reset_n   = 1'b1;
    logic         in_valid  = 1'b0;
    logic         op        = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Sum;
    logic         CO;
    logic         V;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    wide_add_seq #(.NUM_SLICES(NS)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .CO        (CO),
        .V         (V),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic. CO for subtract is "no borrow",
    // V is "exact signed result does not fit in W bits".
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic o,
                         output logic [63:0] s, output logic co, output logic v);
        logic signed [65:0] ex;
        if (!o) begin
            {co, s} = {1'b0, a} + {1'b0, b};
            ex = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        end else begin
            s  = a - b;
            co = (a >= b);
            ex = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        end
        v = ($signed({{2{s[63]}}, s}) != ex);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic o);
        @(negedge Clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        A = a; B = b; op = o; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("busy_run", 64'({busy, in_ready, out_valid}), 64'b100);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input logic [63:0] a, input logic [63:0] b, input logic o);
        logic [63:0] s;
        logic        co;
        logic        v;
        model(a, b, o, s, co, v);
        check("sum", Sum, s);
        check("co", 64'(CO), 64'(co));
        check("v", 64'(V), 64'(v));
    endtask

    task automatic release_out();
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        check("ov_clear", 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic o);
        int cyc;
        issue(a, b, o);
        wait_done(cyc);
        check("latency", 64'(cyc), 64'd4);
        check_result(a, b, o);
        release_out();
    endtask

    initial begin
        logic [63:0] hs;
        logic        hco;
        logic        hv;
        logic [63:0] ra;
        logic [63:0] rb;
        int          cyc;

        // Asynchronous reset at power-up
        #1 Reset_n = 1'b0;
        #1;
        check("rst_flags", 64'({in_ready, out_valid, busy, CO, V}), 64'b10000);
        check("rst_sum", Sum, 64'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed corner cases
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(64'h5, 64'h7, 1'b1);
        run_op(64'h7, 64'h5, 1'b1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        run_op(64'h0, 64'h0, 1'b1);

        // Backpressure: result held, new request pending but not accepted
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        wait_done(cyc);
        check("bp_latency", 64'(cyc), 64'd4);
        check_result(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        hs = Sum; hco = CO; hv = V;
        @(negedge Clk);
        A = 64'hAAAA_0000_5555_FFFF; B = 64'h0000_FFFF_0001_0001; op = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            check("bp_sum_hold", Sum, hs);
            check("bp_flag_hold", 64'({CO, V, out_valid, in_ready}), 64'({hco, hv, 1'b1, 1'b0}));
        end
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("bp_idle_gap", 64'({in_ready, busy, out_valid}), 64'b100);
        out_ready = 1'b0;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("bp_accept", 64'(busy), 64'd1);
        wait_done(cyc);
        check("bp2_latency", 64'(cyc), 64'd4);
        check_result(64'hAAAA_0000_5555_FFFF, 64'h0000_FFFF_0001_0001, 1'b1);
        release_out();

        // Reset asserted during the slice-2 RUN cycle
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_flags", 64'({in_ready, out_valid, busy, CO, V}), 64'b10000);
        check("mid_rst_sum", Sum, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("mid_rst_hold", 64'({out_valid, busy}), 64'b00);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            check("no_phantom", 64'({out_valid, busy}), 64'b00);
        end
        run_op(64'h1, 64'h1, 1'b0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ra[63] = rb[63];
                1: rb = ra;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
